// File: rtl/serial_subtractor_8bit_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_8bit_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor_8bit_if.sv
// Request/result bundle between the ALU subtract path (master) and the serial subtractor (slave).
interface serial_subtractor_8bit_if
  import serial_subtractor_8bit_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout, zero, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout, zero, ovf
  );

endinterface

// File: rtl/serial_subtractor_8bit_full_subtractor.sv
// One-bit full subtractor: diff = x - y - bin, bout set when the bit borrows.
module full_subtractor (
  output logic diff,
  output logic bout,
  input  logic x,
  input  logic y,
  input  logic bin
);

  always_comb begin
    diff = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial D = A - B - Bin, LSB first, one full-subtractor cell with a registered borrow.
module serial_subtractor_8bit
  import serial_subtractor_8bit_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_subtractor_8bit_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             brw_q, brw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic diff_c;
  logic bout_c;

  full_subtractor u_fs (
    .diff (diff_c),
    .bout (bout_c),
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (brw_q)
  );

  // Next-state, datapath and result flags
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    d_d     = d_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          r_sh_d  = '0;
          brw_d   = bus.bin;
          cnt_d   = '0;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        r_sh_d = {diff_c, r_sh_q[WIDTH-1:1]};
        brw_d  = bout_c;
        cnt_d  = cnt_q + CNT_W'(1);
        // Last bit: publish the result and flags in the same edge
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          d_d     = r_sh_d;
          bout_d  = bout_c;
          zero_d  = (r_sh_d == '0);
          ovf_d   = (a_msb_q != b_msb_q) & (r_sh_d[WIDTH-1] != a_msb_q);
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.d    = d_q;
  assign bus.bout = bout_q;
  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;

endmodule
